// File: rtl/complex_fsm.sv
// Cola vending controller: accepts half/one-yuan coins, dispenses at PRICE, refunds on cancel.
// All outputs are registered, so every response appears one cycle after the input.
module complex_fsm #(
   parameter int unsigned PRICE = 5
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       pi_money_half,
   input  logic       pi_money_one,
   input  logic       pi_cancel,
   output logic       po_cola,
   output logic       po_money,
   output logic       po_busy,
   output logic [3:0] po_balance
);

   typedef enum logic [1:0] {StIdle, StCredit, StRefund} state_e;

   localparam logic [3:0] PriceU = 4'(PRICE);

   state_e     state;
   logic [3:0] refund_cnt;
   logic [3:0] coin;
   logic [3:0] sum;

   // A one-yuan coin wins when both coin inputs fire together.
   always_comb begin
      coin = 4'd0;
      if (pi_money_one) begin
         coin = 4'd2;
      end else if (pi_money_half) begin
         coin = 4'd1;
      end
   end

   assign sum = po_balance + coin;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= StIdle;
         refund_cnt <= 4'd0;
         po_cola    <= 1'b0;
         po_money   <= 1'b0;
         po_busy    <= 1'b0;
         po_balance <= 4'd0;
      end else begin
         po_cola  <= 1'b0;
         po_money <= 1'b0;
         case (state)
            StIdle, StCredit: begin
               if (pi_cancel) begin
                  if (sum == 4'd0) begin
                     state   <= StIdle;
                     po_busy <= 1'b0;
                  end else begin
                     // First refund pulse goes out immediately; refund_cnt holds the rest.
                     state      <= StRefund;
                     po_busy    <= 1'b1;
                     po_money   <= 1'b1;
                     refund_cnt <= sum - 4'd1;
                     po_balance <= sum - 4'd1;
                  end
               end else if (coin != 4'd0) begin
                  if (sum >= PriceU) begin
                     state      <= StIdle;
                     po_cola    <= 1'b1;
                     po_money   <= (sum == PriceU + 4'd1);
                     po_balance <= 4'd0;
                  end else begin
                     state      <= StCredit;
                     po_balance <= sum;
                  end
               end
            end
            StRefund: begin
               if (refund_cnt != 4'd0) begin
                  po_money   <= 1'b1;
                  refund_cnt <= refund_cnt - 4'd1;
                  po_balance <= refund_cnt - 4'd1;
               end else begin
                  state   <= StIdle;
                  po_busy <= 1'b0;
               end
            end
            default: begin
               state      <= StIdle;
               refund_cnt <= 4'd0;
               po_busy    <= 1'b0;
               po_balance <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_complex_fsm.sv
// Bench for complex_fsm (PRICE = 5): table of hand-computed vectors plus a mid-refund reset sequence.
module tb_complex_fsm;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       pi_money_half = 1'b0;
   logic       pi_money_one = 1'b0;
   logic       pi_cancel = 1'b0;
   logic       po_cola;
   logic       po_money;
   logic       po_busy;
   logic [3:0] po_balance;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      name;
      logic       half;
      logic       one;
      logic       cancel;
      logic [6:0] exp;   // {cola, money, busy, balance}
   } vec_t;

   vec_t       vecs[$];
   logic [6:0] sb[$];

   complex_fsm #(.PRICE(5)) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .pi_money_half(pi_money_half),
      .pi_money_one (pi_money_one),
      .pi_cancel    (pi_cancel),
      .po_cola      (po_cola),
      .po_money     (po_money),
      .po_busy      (po_busy),
      .po_balance   (po_balance)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] outs();
      return {po_cola, po_money, po_busy, po_balance};
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got cola/money/busy/bal=%b/%b/%b/%0d required %b/%b/%b/%0d",
                  name, act[6], act[5], act[4], act[3:0], exp[6], exp[5], exp[4], exp[3:0]);
      end
   endtask

   task automatic add(input string name, input logic h, input logic o, input logic c,
                      input logic ec, input logic em, input logic eb, input int bal);
      vec_t v;
      v.name   = name;
      v.half   = h;
      v.one    = o;
      v.cancel = c;
      v.exp    = {ec, em, eb, 4'(bal)};
      vecs.push_back(v);
   endtask

   // Drive on the falling edge, compare 1 time unit after the rising edge.
   task automatic step(input string name, input logic h, input logic o, input logic c,
                       input logic [6:0] exp);
      @(negedge sys_clk);
      pi_money_half = h;
      pi_money_one  = o;
      pi_cancel     = c;
      sb.push_back(exp);
      @(posedge sys_clk);
      #1;
      check(name, outs(), sb.pop_front());
   endtask

   initial begin
      // Half coins to exact price
      add("half1",  1,0,0, 0,0,0,1);
      add("half2",  1,0,0, 0,0,0,2);
      add("half3",  1,0,0, 0,0,0,3);
      add("half4",  1,0,0, 0,0,0,4);
      add("half5",  1,0,0, 1,0,0,0);
      add("idle_a", 0,0,0, 0,0,0,0);
      // One-yuan coins overpay by one unit: cola and change together
      add("one1",   0,1,0, 0,0,0,2);
      add("one2",   0,1,0, 0,0,0,4);
      add("one3",   0,1,0, 1,1,0,0);
      add("idle_b", 0,0,0, 0,0,0,0);
      // Cancel with balance 3
      add("c3_one", 0,1,0, 0,0,0,2);
      add("c3_hf",  1,0,0, 0,0,0,3);
      add("c3_can", 0,0,1, 0,1,1,2);
      add("c3_p2",  0,0,0, 0,1,1,1);
      add("c3_p3",  0,0,0, 0,1,1,0);
      add("c3_end", 0,0,0, 0,0,0,0);
      // Balance 4 + cancel + one: 6-unit refund, coins ignored meanwhile
      add("c6_o1",  0,1,0, 0,0,0,2);
      add("c6_o2",  0,1,0, 0,0,0,4);
      add("c6_can", 0,1,1, 0,1,1,5);
      add("c6_p2",  0,1,0, 0,1,1,4);
      add("c6_p3",  1,0,0, 0,1,1,3);
      add("c6_p4",  0,0,1, 0,1,1,2);
      add("c6_p5",  1,1,0, 0,1,1,1);
      add("c6_p6",  0,0,0, 0,1,1,0);
      add("c6_end", 0,0,0, 0,0,0,0);
      add("c6_hf",  1,0,0, 0,0,0,1);
      add("c1_can", 0,0,1, 0,1,1,0);
      add("c1_end", 0,0,0, 0,0,0,0);
      // Both coins together count as one yuan
      add("both",   1,1,0, 0,0,0,2);
      add("b_can",  0,0,1, 0,1,1,1);
      add("b_p2",   0,0,0, 0,1,1,0);
      add("b_end",  0,0,0, 0,0,0,0);
      add("can0",   0,0,1, 0,0,0,0);
      add("can0_b", 0,0,0, 0,0,0,0);
      // Exact-price boundary and both-coins overpay
      add("e_hf",   1,0,0, 0,0,0,1);
      add("e_o1",   0,1,0, 0,0,0,3);
      add("e_o2",   0,1,0, 1,0,0,0);
      add("o_o1",   0,1,0, 0,0,0,2);
      add("o_o2",   0,1,0, 0,0,0,4);
      add("o_both", 1,1,0, 1,1,0,0);
      add("o_end",  0,0,0, 0,0,0,0);

      #1;
      check("reset_state", outs(), 7'b000_0000);
      repeat (2) @(posedge sys_clk);
      check("reset_hold", outs(), 7'b000_0000);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].name, vecs[i].half, vecs[i].one, vecs[i].cancel, vecs[i].exp);
      end

      // Reset during a refund, right after the second pulse
      step("r_o1",  0, 1, 0, 7'b000_0010);
      step("r_o2",  0, 1, 0, 7'b000_0100);
      step("r_can", 0, 0, 1, 7'b011_0011);
      step("r_p2",  0, 0, 0, 7'b011_0010);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("r_async", outs(), 7'b000_0000);
      for (int k = 0; k < 3; k++) begin
         @(posedge sys_clk);
         #1;
         check("r_nopulse", outs(), 7'b000_0000);
      end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      step("r_idle", 0, 0, 0, 7'b000_0000);
      step("r_b1",   0, 1, 0, 7'b000_0010);
      step("r_b2",   0, 1, 0, 7'b000_0100);
      step("r_b3",   1, 0, 0, 7'b100_0000);
      step("r_end",  0, 0, 0, 7'b000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/complex_fsm.md
COMPLEX_FSM -- requirements
Module: complex_fsm

Interface
REQ-001 SHALL declare parameter PRICE, default 5, meaning cola price in half-yuan units (5 = 2.5 yuan); legal range 3..8.
REQ-002 SHALL declare port sys_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL declare port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL declare port pi_money_half  input  1  high for one cycle per 0.5-yuan coin inserted.
REQ-005 SHALL declare port pi_money_one  input  1  high for one cycle per 1-yuan coin inserted.
REQ-006 SHALL declare port pi_cancel  input  1  high for one cycle to request a refund of the current balance.
REQ-007 SHALL declare port po_cola  output  1  one-cycle pulse, one cola dispensed.
REQ-008 SHALL declare port po_money  output  1  one-cycle pulse per 0.5 yuan returned to the customer.
REQ-009 SHALL declare port po_busy  output  1  high while a refund is in progress.
REQ-010 SHALL declare port po_balance  output  4  current credit in half-yuan units.

Function
REQ-011 SHALL register all outputs; an input sampled on edge k produces its response after edge k, one cycle of latency.
REQ-012 SHALL value coins as: pi_money_half = 1 unit, pi_money_one = 2 units; both high in one cycle: accept pi_money_one only, discard pi_money_half.
REQ-013 SHALL implement states IDLE (balance 0), CREDIT (0 < balance < PRICE) and REFUND.
REQ-014 SHALL, in IDLE/CREDIT with a coin and no cancel, form sum = balance + coin; if sum < PRICE, set balance = sum and stay in or enter CREDIT.
REQ-015 SHALL, if sum >= PRICE, pulse po_cola, set balance = 0, go to IDLE, and pulse po_money in the same cycle as po_cola when sum - PRICE = 1.
REQ-016 SHALL never produce sum - PRICE > 1, since balance <= PRICE-1 and the coin is <= 2 units.
REQ-017 SHALL, on pi_cancel in IDLE/CREDIT, set refund count = balance + accepted coin; cancel has priority, so no cola is dispensed that cycle.
REQ-018 SHALL treat a refund count of 0 as a no-op and remain in IDLE with po_busy low.
REQ-019 SHALL, for a refund count N > 0, enter REFUND, raise po_busy, and emit exactly N po_money pulses on N consecutive cycles starting the cycle after the cancel.
REQ-020 SHALL decrement po_balance by 1 with each refund pulse, and drop po_busy and return to IDLE in the cycle after the last pulse.
REQ-021 SHALL ignore and discard coins and pi_cancel while in REFUND.
REQ-022 SHALL size the refund counter for the maximum of PRICE+1 units without wrap-around.
REQ-023 SHALL keep po_cola and po_money low in every cycle not covered by REQ-015 and REQ-019.

Reset
REQ-024 SHALL, on sys_rst_n low, immediately and asynchronously force state IDLE, balance 0, refund count 0, and po_cola = po_money = po_busy = 0, po_balance = 0.
REQ-025 SHALL, on reset asserted mid-refund, abandon the refund with no further po_money pulses; the lost credit is not recovered.
REQ-026 SHALL resume operation on the first rising edge after sys_rst_n deasserts.

Verification
REQ-027 SHALL cover: five pi_money_half pulses -> po_balance 1,2,3,4, then po_cola = 1 for one cycle, po_money = 0, po_balance = 0.
REQ-028 SHALL cover: pi_money_one x3 -> po_balance 2,4, then po_cola = 1 and po_money = 1 in the same cycle, po_balance = 0.
REQ-029 SHALL cover: one + half, then pi_cancel -> po_busy = 1 for 3 cycles, 3 po_money pulses, po_balance 3->2->1->0, no po_cola.
REQ-030 SHALL cover: balance 4 with pi_cancel and pi_money_one in the same cycle -> no po_cola, 6 po_money pulses; coins during the refund are ignored.
REQ-031 SHALL cover: pi_money_half and pi_money_one in the same cycle from IDLE -> po_balance = 2.
REQ-032 SHALL cover: reset asserted after the 2nd refund pulse -> all outputs 0 at once, no further pulses, then a normal purchase succeeds after release.
